// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder plus a carry flip-flop, LSB first, parallel load/unload.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sh, b_sh, res_sh, res_nxt;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           ha0_s, ha0_c, ha1_c, fa_s, fa_c;

  // Full adder as two half adders; the carry OR is a nand2 of the inverted half-adder carries.
  always_comb begin
    ha0_s = a_sh[0] ^ b_sh[0];
    ha0_c = a_sh[0] & b_sh[0];
    fa_s  = ha0_s ^ carry;
    ha1_c = ha0_s & carry;
    fa_c  = ~(~ha0_c & ~ha1_c);
  end

  always_comb begin
    last         = (cnt == CW'(N - 1));
    res_nxt      = res_sh >> 1;
    res_nxt[N-1] = fa_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into bit N-1 on this edge
        ovf  <= carry ^ fa_c;
`endif
      end
    end else if (start) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
// Define SERIAL_ADDER_OVF_EN for both files to exercise the overflow output.
module tb_serial_adder;

  parameter int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [N-1:0] a, b;
  logic         busy, done, cout;
  logic [N-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;
  logic         held_ovf  = 1'b0;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (N+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    longint sx, sy, r, hi, lo;
    sx = $signed(x);
    sy = $signed(y);
    r  = sx + sy + longint'(c);
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -(longint'(1) <<< (N - 1));
    return (r > hi) || (r < lo);
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    for (int i = 0; i < N; i += 32) v = (v << 32) | N'($urandom);
    return v;
  endfunction

  task automatic check_held(input string pfx);
    check({pfx, "_sum_held"},  longint'(sum),  longint'(held_sum));
    check({pfx, "_cout_held"}, longint'(cout), longint'(held_cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({pfx, "_ovf_held"},  longint'(ovf),  longint'(held_ovf));
`endif
  endtask

  // Entered with the DUT in IDLE or DONE. chain keeps start high so the DONE cycle
  // launches the next operation; poke_at/rst_at index the RUN cycle to disturb (-1 = none).
  task automatic do_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input logic op_cin,
                       input int poke_at, input int rst_at, input bit chain);
    logic [N:0] exp;
    logic       exp_ovf;
    exp     = ref_add(op_a, op_b, op_cin);
    exp_ovf = ref_ovf(op_a, op_b, op_cin);
    a = op_a; b = op_b; cin = op_cin; start = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      if (i == rst_at) begin
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check_held("rst");
        tick();
        check("rst_no_done", longint'(done), 0);
        check("rst_idle_busy", longint'(busy), 0);
        return;
      end
      check("run_busy", longint'(busy), 1);
      check("run_done", longint'(done), 0);
      check_held("run");
      a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
      if (i == poke_at) begin
        a = N'(1); b = N'(1); start = 1'b1;
      end else begin
        start = chain;
      end
      tick();
    end
    held_sum = exp[N-1:0]; held_cout = exp[N]; held_ovf = exp_ovf;
    check("fin_done", longint'(done), 1);
    check("fin_busy", longint'(busy), 0);
    check("fin_sum",  longint'(sum),  longint'(exp[N-1:0]));
    check("fin_cout", longint'(cout), longint'(exp[N]));
`ifdef SERIAL_ADDER_OVF_EN
    check("fin_ovf",  longint'(ovf),  longint'(exp_ovf));
`endif
    if (!chain) begin
      start = 1'b0;
      tick();
      check("post_done", longint'(done), 0);
      check("post_busy", longint'(busy), 0);
      check_held("post");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check_held("reset");

    do_op(N'(8'h5A), N'(8'h33), 1'b0, -1, -1, 1'b0);
    do_op(N'(8'hFF), N'(8'h01), 1'b0, -1, -1, 1'b0);
    do_op(N'(8'hFF), N'(8'h00), 1'b1, -1, -1, 1'b0);
    do_op('1, '0, 1'b1, -1, -1, 1'b0);
    do_op('1, '1, 1'b1, -1, -1, 1'b0);

    // start pulse mid-run must be ignored
    do_op(N'(8'hC3), N'(8'h5E), 1'b1, (N > 3) ? 3 : N - 1, -1, 1'b0);

    // reset mid-run, then a clean operation
    do_op(N'(8'h77), N'(8'h99), 1'b0, -1, (N > 4) ? 4 : N - 1, 1'b0);
    do_op(N'(8'h12), N'(8'h34), 1'b1, -1, -1, 1'b0);

    // back-to-back with start held high
    for (int k = 0; k < 6; k++) begin
      if (k[0]) do_op(N'(8'hA5), N'(8'h5A), 1'b1, -1, -1, 1'b1);
      else      do_op(rnd_op(), rnd_op(), 1'($urandom), -1, -1, 1'b1);
    end
    start = 1'b0;
    tick();
    check("chain_end_done", longint'(done), 0);
    check("chain_end_busy", longint'(busy), 0);

    do_op(N'(8'h7F), N'(8'h01), 1'b0, -1, -1, 1'b0);
    do_op(N'(8'h80), N'(8'h80), 1'b0, -1, -1, 1'b0);
    do_op(N'(8'h10), N'(8'h20), 1'b0, -1, -1, 1'b0);

    for (int k = 0; k < 40; k++)
      do_op(rnd_op(), rnd_op(), 1'($urandom), -1, -1, 1'($urandom_range(0, 1)));
    start = 1'b0;
    tick();
    check("rand_end_busy", longint'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
